move_sequencer: RTL

MOVE_SEQUENCER -- requirements
Module: move_sequencer

---
 rtl/move_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/move_sequencer.sv
// move_sequencer: queues move codes from the solver and issues them one at a
// time to the stepper stage, waiting for the steppers to go idle and then
// settle before the next move is issued.
module move_sequencer #(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned START_WINDOW  = 8,
  parameter int unsigned SETTLE_CYCLES = 1000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               move_in,
  input  logic                     move_in_valid,
  output logic                     move_in_ready,
  input  logic                     run,
  output logic [3:0]               next_move,
  output logic                     move_start,
  input  logic                     move_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_count,
  output logic                     seq_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned WW = (START_WINDOW  > 1) ? $clog2(START_WINDOW)  : 1;
  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WW-1:0] WIN_LAST    = WW'(START_WINDOW - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [AW:0]   FULL_COUNT  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ACK,
    WAIT_DONE,
    SETTLE
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     count_q;
  logic [3:0]      next_move_q;
  logic [WW-1:0]   win_q, win_d;
  logic [SW-1:0]   settle_q, settle_d;

  logic            push, pop;
  logic [3:0]      head;
  logic            head_ok;

  // Queue handshake and head decode; full blocks writes even in a pop cycle.
  always_comb begin
    move_in_ready = (count_q != FULL_COUNT);
    push          = move_in_valid && move_in_ready;
    pop           = (state_q == IDLE) && run && (count_q != '0);
    head          = mem_q[rptr_q];
    head_ok       = (head >= 4'd2) && (head <= 4'd13);
  end

  // Circular FIFO storage, pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= move_in;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // next_move only changes when a valid code is popped in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) next_move_q <= 4'hF;
    else if (pop && head_ok) next_move_q <= head;
  end

  // State and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      settle_q <= settle_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pop && head_ok) state_d = START;
      START:     state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (!move_done)              state_d = WAIT_DONE;
        else if (win_q == WIN_LAST)  state_d = SETTLE;
      end
      WAIT_DONE: if (move_done) state_d = SETTLE;
      SETTLE:    if (settle_q == SETTLE_LAST) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Window and settle counters; each is cleared on the way into its state.
  always_comb begin
    win_d    = win_q;
    settle_d = settle_q;
    case (state_q)
      START:     win_d    = '0;
      WAIT_ACK: begin
        win_d    = win_q + 1'b1;
        settle_d = '0;
      end
      WAIT_DONE: settle_d = '0;
      SETTLE:    settle_d = settle_q + 1'b1;
      default: begin
        win_d    = win_q;
        settle_d = settle_q;
      end
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    move_start  = (state_q == START);
    busy        = (state_q != IDLE);
    seq_empty   = (state_q == IDLE) && (count_q == '0);
    next_move   = next_move_q;
    queue_count = count_q;
  end

endmodule
